// File: rtl/rx_align_pkg.sv
// Shared types and helpers for the receive word aligner.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package rx_align_pkg;

    localparam int ERR_W = 8;

    // Widest word the candidate helper supports (STAGES up to 6).
    localparam int MAX_W = 64;

    typedef enum logic [2:0] {
        IDLE,
        SEARCH,
        CONFIRM,
        LOCKED,
        FAIL
    } state_t;

    // Candidate word starting at bit offset s of the two-word window.
    // Callers zero-extend their window to 2*MAX_W and keep the low W bits.
    function automatic logic [MAX_W-1:0] cand_of(input logic [2*MAX_W-1:0] cat,
                                                 input int                 s);
        return MAX_W'(cat >> s);
    endfunction

endpackage

// File: rtl/rx_align_match.sv
// Compares every bit offset of the two-word window against the training word.
// Latency: purely combinational.
// Backpressure: none.
module rx_align_match
    import rx_align_pkg::*;
#(
    parameter  int STAGES = 5,
    localparam int W      = 2**STAGES
) (
    input  logic [2*W-1:0]    cat,
    input  logic [W-1:0]      train_pattern,
    output logic [W-1:0]      m,
    output logic              any_match,
    output logic [STAGES-1:0] first_idx
);

    // One equality comparator per candidate offset.
    always_comb begin
        m = '0;
        for (int s = 0; s < W; s++) begin
            m[s] = (W'(cand_of((2*MAX_W)'(cat), s)) == train_pattern);
        end
    end

    // Lowest matching offset wins; scanning downwards lets the last hit stick.
    always_comb begin
        first_idx = '0;
        for (int s = W - 1; s >= 0; s--) begin
            if (m[s]) begin
                first_idx = STAGES'(s);
            end
        end
    end

    assign any_match = |m;

endmodule

// File: rtl/rx_word_aligner.sv
// Finds the bit offset of a training word in the deserialized stream, locks and emits aligned words.
// Latency: 1 clk from des_dout to dout.
// Backpressure: none; one word is consumed every clk and there is no stall input.
module rx_word_aligner
    import rx_align_pkg::*;
#(
    parameter  int STAGES         = 5,
    parameter  int LOCK_COUNT     = 4,
    parameter  int ERR_THRESH     = 8,
    parameter  int SEARCH_TIMEOUT = 256,
    localparam int W              = 2**STAGES
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic [W-1:0]      des_dout,
    input  logic [W-1:0]      train_pattern,
    input  logic              align_start,
    input  logic              train_active,
    output logic [W-1:0]      dout,
    output logic              dout_valid,
    output logic              locked,
    output logic [STAGES-1:0] shift,
    output logic [ERR_W-1:0]  err_count,
    output logic              align_fail
);

    localparam int CNT_W  = $clog2(LOCK_COUNT + 1);
    localparam int ERRS_W = $clog2(ERR_THRESH + 1);
    localparam int TMR_W  = $clog2(SEARCH_TIMEOUT + 1);

    state_t              state;
    state_t              state_nxt;
    logic [W-1:0]        prev;
    logic [2*W-1:0]      cat;
    logic [W-1:0]        m;
    logic                any_match;
    logic [STAGES-1:0]   first_idx;
    logic                hit;

    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_nxt;
    logic [CNT_W-1:0]    cnt_inc;
    logic [ERRS_W-1:0]   errs;
    logic [ERRS_W-1:0]   errs_nxt;
    logic [ERRS_W-1:0]   errs_inc;
    logic [TMR_W-1:0]    timer;
    logic [TMR_W-1:0]    timer_nxt;
    logic [TMR_W-1:0]    timer_inc;
    logic                timed_out;
    logic [STAGES-1:0]   shift_nxt;
    logic [ERR_W-1:0]    err_count_nxt;
    logic                align_fail_nxt;

    // Bit 0 is the earliest bit, so the previous word forms the low half of the window.
    assign cat = {des_dout, prev};

    rx_align_match #(
        .STAGES (STAGES)
    ) u_match (
        .cat           (cat),
        .train_pattern (train_pattern),
        .m             (m),
        .any_match     (any_match),
        .first_idx     (first_idx)
    );

    assign hit       = m[shift];
    assign cnt_inc   = cnt + 1'b1;
    assign errs_inc  = errs + 1'b1;
    assign timer_inc = timer + 1'b1;
    assign timed_out = (timer_inc == TMR_W'(SEARCH_TIMEOUT));
    assign locked    = (state == LOCKED);

    // Next-state and counter updates; align_start overrides everything else.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        errs_nxt       = errs;
        timer_nxt      = timer;
        shift_nxt      = shift;
        err_count_nxt  = err_count;
        align_fail_nxt = align_fail;

        if (align_start) begin
            state_nxt      = SEARCH;
            cnt_nxt        = '0;
            errs_nxt       = '0;
            timer_nxt      = '0;
            err_count_nxt  = '0;
            align_fail_nxt = 1'b0;
        end else begin
            case (state)
                SEARCH: begin
                    timer_nxt = timer_inc;
                    if (timed_out) begin
                        state_nxt      = FAIL;
                        align_fail_nxt = 1'b1;
                    end else if (any_match) begin
                        shift_nxt = first_idx;
                        cnt_nxt   = CNT_W'(1);
                        if (LOCK_COUNT == 1) begin
                            // A relock later gets a full search budget.
                            state_nxt = LOCKED;
                            timer_nxt = '0;
                            errs_nxt  = '0;
                        end else begin
                            state_nxt = CONFIRM;
                        end
                    end
                end
                CONFIRM: begin
                    timer_nxt = timer_inc;
                    if (timed_out) begin
                        state_nxt      = FAIL;
                        align_fail_nxt = 1'b1;
                    end else if (hit) begin
                        cnt_nxt = cnt_inc;
                        if (cnt_inc == CNT_W'(LOCK_COUNT)) begin
                            state_nxt = LOCKED;
                            timer_nxt = '0;
                            errs_nxt  = '0;
                        end
                    end else begin
                        // The timer keeps running across a failed confirm.
                        state_nxt = SEARCH;
                        cnt_nxt   = '0;
                    end
                end
                LOCKED: begin
                    if (train_active && !hit) begin
                        err_count_nxt = (err_count == '1) ? err_count : err_count + 1'b1;
                        errs_nxt      = errs_inc;
                        if (errs_inc == ERRS_W'(ERR_THRESH)) begin
                            // err_count is kept so the relock cause stays visible.
                            state_nxt = SEARCH;
                            cnt_nxt   = '0;
                            errs_nxt  = '0;
                        end
                    end
                end
                default: begin
                    // IDLE and FAIL wait for align_start.
                end
            endcase
        end
    end

    // FSM state and counter registers.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state      <= IDLE;
            cnt        <= '0;
            errs       <= '0;
            timer      <= '0;
            shift      <= '0;
            err_count  <= '0;
            align_fail <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            errs       <= errs_nxt;
            timer      <= timer_nxt;
            shift      <= shift_nxt;
            err_count  <= err_count_nxt;
            align_fail <= align_fail_nxt;
        end
    end

    // Window history and aligned output word; dout holds outside LOCKED.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            prev       <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            prev <= des_dout;
            if (state == LOCKED) begin
                dout <= W'(cand_of((2*MAX_W)'(cat), int'(shift)));
            end
            dout_valid <= (state == LOCKED) && !train_active;
        end
    end

endmodule

// File: doc/rx_word_aligner.md
Name: rx_word_aligner

Overview:
- Sequences word framing for the tree deserializer. Runs on the slowest divided deserializer clock and takes one 2**STAGES-bit parallel word per cycle; bit 0 is the earliest received bit.
- During link training it searches all bit offsets for a known training pattern, confirms lock, then emits word-aligned data.
- It monitors pattern errors while training is active and relocks automatically when errors accumulate.

Parameters:
- STAGES, 5, deserializer tree depth; word width W = 2**STAGES.
- LOCK_COUNT, 4, consecutive matches at the same offset needed to declare lock (>=1).
- ERR_THRESH, 8, errored words while locked and training that force relock (>=1).
- SEARCH_TIMEOUT, 256, SEARCH+CONFIRM cycles before declaring failure.

Ports:
- clk  input  1  divided word clock (deserializer top-stage clock).
- rstb  input  1  asynchronous active-low reset.
- des_dout  input  W  raw word from the tree deserializer.
- train_pattern  input  W  expected training word, quasi-static.
- align_start  input  1  single-cycle pulse; starts or restarts alignment from any state.
- train_active  input  1  the far end is transmitting train_pattern.
- dout  output  W  aligned data word.
- dout_valid  output  1  dout is aligned, data-valid.
- locked  output  1  alignment is held.
- shift  output  STAGES  current bit offset.
- err_count  output  8  errored words since lock, saturating at 255.
- align_fail  output  1  sticky search timeout.

Behaviour:
- Reset (rstb low, asynchronous): state IDLE; prev=0; dout=0; dout_valid=0; locked=0; shift=0; err_count=0; align_fail=0; all internal counters 0.
- Window: every cycle prev<=des_dout. The window is cat = {des_dout, prev} (2W bits), and cand(s) = cat[s+W-1:s] for s = 0..W-1.
- Match vector: m[s] = (cand(s) == train_pattern). Priority is the lowest matching s.
- States:
  - IDLE: outputs hold. align_start -> SEARCH; clears align_fail, err_count and timer.
  - SEARCH: if any m[s], latch shift<=lowest s, set cnt=1, go to CONFIRM; if LOCK_COUNT==1, go straight to LOCKED.
  - CONFIRM: m[shift] -> cnt++; when cnt reaches LOCK_COUNT -> LOCKED. !m[shift] -> back to SEARCH; cnt=0, timer continues.
  - Timeout: timer counts every cycle in SEARCH and CONFIRM. When it reaches SEARCH_TIMEOUT -> FAIL with align_fail=1.
  - LOCKED: locked=1. If train_active && !m[shift], err_count++ (saturating) and errs++. When errs reaches ERR_THRESH -> SEARCH; locked drops the next cycle and err_count is retained.
  - FAIL: holds until align_start.
- Output: dout <= cand(shift) registered every cycle in LOCKED. dout_valid <= (state==LOCKED) && !train_active. Latency is 1 clk from des_dout to dout.
- Outside LOCKED: dout holds its last value and dout_valid=0.
- align_start in any state, including LOCKED or mid-CONFIRM, restarts SEARCH the next cycle with locked=0.
- align_start has priority over every other transition in the same cycle.
- Equality on the lock threshold edge: the transition happens on the cycle the count reaches the threshold, not one later.
- shift is stable whenever locked=1.
- All-zero or periodic patterns can match multiple offsets. The lowest offset is taken by design; choosing an aperiodic pattern is the trainer's responsibility.

Decomposition:
- Package rx_align_pkg:
  - state enum: IDLE, SEARCH, CONFIRM, LOCKED, FAIL.
  - function computing cand for a given shift.
  - ERR_W = 8.
- Sub-module rx_align_match (combinational): cat and train_pattern -> m[W-1:0], any_match, first_idx[STAGES-1:0]. The rest (FSM, counters, output register) stays in the top.

Test Plan:
- Reset, then align_start; drive pattern 32'hA5C3_0F96 with a stream offset of 7 bits, train_active=1 -> after the match plus 3 more matches, locked=1 and shift=7; dout_valid stays 0.
- Same lock, then drop train_active and send random words -> each random word appears on dout exactly 1 clk after the word that completes it; dout_valid=1.
- Locked with train_active=1; corrupt 8 pattern words -> err_count=8, locked=0 the next cycle, state SEARCH. Clean pattern then relocks at the same offset.
- align_start with des_dout constant 0 and pattern nonzero -> after 256 cycles align_fail=1, locked=0; a second align_start clears align_fail.
- Offset 0 and offset 31 streams -> shift=0 and shift=31 respectively. A single corrupted word during CONFIRM returns to SEARCH and needs 4 fresh matches.
- Assert rstb low mid-CONFIRM -> all outputs 0 immediately (asynchronous reset); no lock after release until align_start.
